// File: rtl/pru_bringup_sequencer_if.sv
// pru_bringup_sequencer_if: control, status and bus-link stimulus signals of the bring-up sequencer.
interface pru_bringup_sequencer_if #(
    parameter int unsigned NUM_LANES = 4
);
    logic                 start;
    logic                 abort;
    logic                 cpu_rst_n;
    logic                 vga_clk_en;
    logic                 vga_read;
    logic                 bl_stall;
    logic [NUM_LANES-1:0] bl_strobe;
    logic                 busy;
    logic                 done;
    logic [31:0]          run_cnt;
    modport master (
        input  start, abort,
        output cpu_rst_n, vga_clk_en, vga_read, bl_stall, bl_strobe, busy, done, run_cnt
    );
    modport slave (
        output start, abort,
        input  cpu_rst_n, vga_clk_en, vga_read, bl_stall, bl_strobe, busy, done, run_cnt
    );
endinterface

// File: rtl/pru_bringup_sequencer.sv
// pru_bringup_sequencer: holds the CPU in reset, warms up, then runs VGA reads with
// pseudo-random bus-link stalls and walking strobes; also emits a divided VGA clock enable.
module pru_bringup_sequencer #(
    parameter int unsigned NUM_LANES     = 4,
    parameter int unsigned RST_CYCLES    = 2,
    parameter int unsigned WARMUP_CYCLES = 200,
    parameter int unsigned RUN_CYCLES    = 1000000,
    parameter int unsigned VGA_DIV       = 2,
    parameter int unsigned STALL_THRESH  = 0,
    parameter int unsigned MAX_STALL     = 8,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input logic                     clk,
    input logic                     rst,
    pru_bringup_sequencer_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_RESET, S_WARMUP, S_RUN, S_DONE} state_t;
    localparam int unsigned RST_LEN = (RST_CYCLES == 0) ? 1 : RST_CYCLES;
    state_t               r_state;
    logic [31:0]          r_phase;
    logic [31:0]          r_run_cnt;
    logic [31:0]          r_stall_run;
    logic [31:0]          r_div;
    logic [15:0]          r_lfsr;
    logic [NUM_LANES-1:0] r_pos;
    logic [NUM_LANES-1:0] r_strobe;
    logic                 r_cpu_rst_n;
    logic                 r_vga_read;
    logic                 r_stall;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_vga_en;
    logic [15:0]          w_lfsr_nx;
    logic [NUM_LANES-1:0] w_pos_nx;
    logic [31:0]          w_div_nx;
    logic                 w_stall_nx;
    logic                 w_to_done;
    logic                 w_to_run;
    logic                 w_start;
    assign w_lfsr_nx  = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    assign w_stall_nx = ({24'd0, r_lfsr[7:0]} < STALL_THRESH) && (r_stall_run < MAX_STALL);
    // the lane position only advances on cycles that actually presented a strobe
    assign w_pos_nx   = r_stall ? r_pos : ((r_pos << 1) | (r_pos >> (NUM_LANES - 1)));
    assign w_div_nx   = (r_div == VGA_DIV - 1) ? 32'd0 : r_div + 32'd1;
    assign w_to_done  = r_busy && (bus.abort || (r_state == S_RUN && RUN_CYCLES != 0 && r_phase == 32'd1));
    assign w_to_run   = !bus.abort && r_phase == 32'd1 &&
                        (r_state == S_WARMUP || (r_state == S_RESET && WARMUP_CYCLES == 0));
    assign w_start    = !r_busy && bus.start && !bus.abort;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_phase     <= '0;
            r_run_cnt   <= '0;
            r_stall_run <= '0;
            r_lfsr      <= LFSR_SEED;
            r_pos       <= '0;
            r_strobe    <= '0;
            r_cpu_rst_n <= 1'b0;
            r_vga_read  <= 1'b0;
            r_stall     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (r_state == S_RUN) begin
                r_lfsr <= w_lfsr_nx;
                if (!(&r_run_cnt)) r_run_cnt <= r_run_cnt + 32'd1;
            end
            if (w_to_done) begin
                r_state     <= S_DONE;
                r_cpu_rst_n <= 1'b1;
                r_vga_read  <= 1'b0;
                r_stall     <= 1'b0;
                r_strobe    <= '0;
                r_busy      <= 1'b0;
                r_done      <= 1'b1;
            end else if (w_to_run) begin
                r_state     <= S_RUN;
                r_phase     <= RUN_CYCLES;
                r_cpu_rst_n <= 1'b1;
                r_vga_read  <= 1'b1;
                r_stall     <= 1'b0;
                r_pos       <= NUM_LANES'(1);
                r_strobe    <= NUM_LANES'(1);
            end else if (w_start) begin
                r_state     <= S_RESET;
                r_phase     <= RST_LEN;
                r_lfsr      <= LFSR_SEED;
                r_run_cnt   <= '0;
                r_stall_run <= '0;
                r_cpu_rst_n <= 1'b0;
                r_busy      <= 1'b1;
                r_done      <= 1'b0;
            end else if (r_state == S_RESET && r_phase == 32'd1) begin
                r_state     <= S_WARMUP;
                r_phase     <= WARMUP_CYCLES;
                r_cpu_rst_n <= 1'b1;
            end else if (r_state == S_RUN) begin
                r_phase     <= r_phase - 32'd1;
                r_stall     <= w_stall_nx;
                r_stall_run <= w_stall_nx ? r_stall_run + 32'd1 : 32'd0;
                r_pos       <= w_pos_nx;
                r_strobe    <= w_stall_nx ? '0 : w_pos_nx;
            end else if (r_busy) begin
                r_phase     <= r_phase - 32'd1;
            end
        end
    end
    // free-running divider, deliberately independent of the sequencer state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div    <= '0;
            r_vga_en <= 1'b0;
        end else begin
            r_div    <= w_div_nx;
            r_vga_en <= (w_div_nx == VGA_DIV - 1);
        end
    end
    assign bus.cpu_rst_n  = r_cpu_rst_n;
    assign bus.vga_clk_en = r_vga_en;
    assign bus.vga_read   = r_vga_read;
    assign bus.bl_stall   = r_stall;
    assign bus.bl_strobe  = r_strobe;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.run_cnt    = r_run_cnt;
endmodule
